vol_flag_ctrl: RTL and testbench



---
 rtl/vol_flag_pkg.sv | 14 +
 rtl/vol_flag_ctrl_debounce.sv | 58 +++++
 rtl/vol_flag_ctrl.sv | 105 ++++++++++
 tb/tb_vol_flag_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vol_flag_pkg.sv
// Shared constants for the volume-flag controller: register offsets and
// the power-on debounce threshold.
package vol_flag_pkg;

    // Avalon register offsets
    localparam logic [1:0] REG_STATUS = 2'd0;  // RO  {0, stable}
    localparam logic [1:0] REG_MASK   = 2'd1;  // RW  irq_mask
    localparam logic [1:0] REG_EDGE   = 2'd2;  // W1C edge_cap
    localparam logic [1:0] REG_THRESH = 2'd3;  // RW  debounce threshold

    // Threshold loaded at reset, in clk cycles
    localparam int DEFAULT_DEBOUNCE_C = 1000;

endpackage

// File: rtl/vol_flag_ctrl_debounce.sv
// One flag channel: two-flop synchroniser, debounce counter, stable output
// and a one-cycle rise pulse that coincides with the stable 0->1 update.
module vol_flag_debounce #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flag,
    input  logic [CNT_W-1:0] i_eff_thr,   // already clamped to >= 1
    output logic             o_stable,
    output logic             o_rise
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W:0]   w_cnt_inc;          // one bit wider so +1 cannot wrap
    logic             w_differs;
    logic             w_update;

    assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_differs = (r_sync2 != r_stable);
    // Compare against the live threshold so a rewrite applies immediately
    assign w_update  = w_differs && (w_cnt_inc >= {1'b0, i_eff_thr});

    // Synchronise the asynchronous flag into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_flag;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive cycles of disagreement; commit when threshold reached
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!w_differs) begin
            r_cnt    <= '0;
        end else if (w_update) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= w_cnt_inc[CNT_W-1:0];
        end
    end

    assign o_stable = r_stable;
    // Rising commit only; falling edges are deliberately not reported
    assign o_rise   = w_update && r_sync2;

endmodule

// File: rtl/vol_flag_ctrl.sv
// Volume-flag controller: per-channel debounce, sticky rising-edge capture,
// maskable level interrupt and an Avalon-MM register slave.
//
// Bus protocol: a write happens on any clock edge where chipselect is high
// and write_n is low. There is no read strobe: readdata is re-registered
// from the addressed register every cycle, so it is valid one cycle after
// the address is presented and shows the state before a same-cycle write.
module vol_flag_ctrl
    import vol_flag_pkg::*;
#(
    parameter int NUM_FLAGS        = 4,
    parameter int CNT_W            = 16,
    parameter int DEFAULT_DEBOUNCE = DEFAULT_DEBOUNCE_C
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    input  logic [NUM_FLAGS-1:0] flag_in,
    output logic                 irq
);

    logic [NUM_FLAGS-1:0] r_mask;
    logic [NUM_FLAGS-1:0] r_edge;
    logic [CNT_W-1:0]     r_thr;
    logic [31:0]          r_readdata;
    logic                 r_irq;

    logic                 w_wr;
    logic [CNT_W-1:0]     w_eff_thr;
    logic [NUM_FLAGS-1:0] w_stable;
    logic [NUM_FLAGS-1:0] w_rise;
    logic [NUM_FLAGS-1:0] w_w1c;
    logic [31:0]          w_rd_mux;
    logic                 w_unused_wdata;

    assign w_wr           = chipselect && !write_n;
    // A zero threshold behaves as one cycle
    assign w_eff_thr      = (r_thr == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : r_thr;
    assign w_w1c          = (w_wr && address == REG_EDGE) ? writedata[NUM_FLAGS-1:0] : '0;
    assign w_unused_wdata = ^writedata;

    for (genvar g = 0; g < NUM_FLAGS; g++) begin : g_chan
        vol_flag_debounce #(
            .CNT_W     (CNT_W)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .i_flag    (flag_in[g]),
            .i_eff_thr (w_eff_thr),
            .o_stable  (w_stable[g]),
            .o_rise    (w_rise[g])
        );
    end

    // Software-writable configuration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
            r_thr  <= CNT_W'(DEFAULT_DEBOUNCE);
        end else if (w_wr) begin
            if (address == REG_MASK)   r_mask <= writedata[NUM_FLAGS-1:0];
            if (address == REG_THRESH) r_thr  <= writedata[CNT_W-1:0];
        end
    end

    // Sticky edge bits: clear by W1C, a same-cycle rise wins over the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge <= '0;
        end else begin
            r_edge <= (r_edge & ~w_w1c) | w_rise;
        end
    end

    // Read mux; unused upper bits stay zero
    always_comb begin
        w_rd_mux = '0;
        case (address)
            REG_STATUS: w_rd_mux[NUM_FLAGS-1:0] = w_stable;
            REG_MASK:   w_rd_mux[NUM_FLAGS-1:0] = r_mask;
            REG_EDGE:   w_rd_mux[NUM_FLAGS-1:0] = r_edge;
            REG_THRESH: w_rd_mux[CNT_W-1:0]     = r_thr;
            default:    w_rd_mux                = '0;
        endcase
    end

    // Registered read data and level interrupt
    always_ff @(posedge clk) begin
        if (reset) begin
            r_readdata <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_readdata <= w_rd_mux;
            r_irq      <= |(r_edge & r_mask);
        end
    end

    assign readdata = r_readdata;
    assign irq      = r_irq;

endmodule

// File: tb/tb_vol_flag_ctrl.sv
// Directed bench for vol_flag_ctrl with NUM_FLAGS=4, CNT_W=16.
module tb_vol_flag_ctrl;

  localparam int NF = 4;

  logic          clk;
  logic          reset;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [NF-1:0] flag_in;
  logic          irq;

  int n_checks;
  int n_errors;
  logic [31:0] rd;

  vol_flag_ctrl #(
    .NUM_FLAGS        (NF),
    .CNT_W            (16),
    .DEFAULT_DEBOUNCE (1000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .flag_in    (flag_in),
    .irq        (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, land 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    step();
    d = readdata;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    flag_in    = 4'hF;

    // Reset: flags high must not leak through
    repeat (3) step();
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset   = 1'b0;
    flag_in = 4'h0;
    bus_read(2'd3, rd); check("reset_thr", rd, 32'd1000);
    bus_read(2'd1, rd); check("reset_mask", rd, 32'h0);
    bus_read(2'd2, rd); check("reset_edge", rd, 32'h0);
    bus_read(2'd0, rd); check("reset_status", rd, 32'h0);

    // Debounce: thr=5 -> stable at 7th edge, visible on readdata at 8th
    bus_write(2'd3, 32'd5);
    bus_write(2'd1, 32'h1);
    bus_write(2'd0, 32'hF);  // status is read-only
    address    = 2'd0;
    flag_in[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 7) begin
        check("deb_status_e7", readdata, 32'h0);
        check("deb_irq_e7", {31'b0, irq}, 32'h0);
      end
      if (k == 8) begin
        check("deb_status_e8", readdata, 32'h1);
        check("deb_irq_e8", {31'b0, irq}, 32'h1);
      end
    end
    bus_read(2'd2, rd); check("deb_edge", rd, 32'h1);

    // Clear edge 0: irq drops one cycle after the write
    bus_write(2'd2, 32'h1);
    check("w1c_irq_same", {31'b0, irq}, 32'h1);
    step();
    check("w1c_irq_after", {31'b0, irq}, 32'h0);

    // Glitch rejection: 4-cycle pulse on flag 2 with thr=5
    flag_in[2] = 1'b1;
    repeat (4) step();
    flag_in[2] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("glitch_irq", {31'b0, irq}, 32'h0);
    end
    bus_read(2'd0, rd); check("glitch_status", rd, 32'h1);
    bus_read(2'd2, rd); check("glitch_edge", rd, 32'h0);

    // W1C race on channel 1: set wins
    flag_in[1] = 1'b1;
    repeat (8) step();
    bus_read(2'd2, rd); check("race_pre_edge", rd, 32'h2);
    flag_in[1] = 1'b0;
    repeat (8) step();
    bus_read(2'd0, rd); check("race_fall_status", rd, 32'h1);
    bus_read(2'd2, rd); check("race_fall_no_cap", rd, 32'h2);
    flag_in[1] = 1'b1;
    repeat (6) step();
    bus_write(2'd2, 32'h2);  // lands on the stable rise edge
    bus_read(2'd2, rd); check("race_set_wins", rd, 32'h2);
    bus_read(2'd0, rd); check("race_status", rd, 32'h3);
    bus_write(2'd1, 32'h2);
    step();
    check("race_irq_masked_in", {31'b0, irq}, 32'h1);
    bus_write(2'd2, 32'h2);
    check("race_irq_same", {31'b0, irq}, 32'h1);
    step();
    check("race_irq_drop", {31'b0, irq}, 32'h0);
    bus_read(2'd2, rd); check("race_cleared", rd, 32'h0);

    // Mask and zero threshold: thr=0 acts as 1 -> stable at 3rd edge
    bus_write(2'd1, 32'h0);
    bus_write(2'd3, 32'h0);
    address    = 2'd0;
    flag_in[3] = 1'b1;
    step(); step(); step();
    check("thr0_status_e3", readdata, 32'h3);
    step();
    check("thr0_status_e4", readdata, 32'hB);
    step();
    check("mask0_irq", {31'b0, irq}, 32'h0);
    bus_read(2'd2, rd); check("mask0_edge", rd, 32'h8);
    bus_read(2'd3, rd); check("thr0_readback", rd, 32'h0);
    bus_write(2'd1, 32'h8);
    check("mask8_irq_same", {31'b0, irq}, 32'h0);
    step();
    check("mask8_irq_next", {31'b0, irq}, 32'h1);

    // Mid-operation reset while channel 0 counter is at 3 of thr=5
    bus_write(2'd2, 32'hF);
    bus_write(2'd3, 32'd5);
    bus_write(2'd1, 32'hF);
    flag_in = 4'h0;
    repeat (8) step();
    bus_read(2'd0, rd); check("mrst_pre_status", rd, 32'h0);
    check("mrst_pre_irq", {31'b0, irq}, 32'h0);
    flag_in[0] = 1'b1;
    repeat (5) step();
    reset = 1'b1;
    repeat (2) begin
      step();
      check("mrst_irq_in_reset", {31'b0, irq}, 32'h0);
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("mrst_irq_after", {31'b0, irq}, 32'h0);
    end
    bus_read(2'd0, rd); check("mrst_status", rd, 32'h0);
    bus_read(2'd2, rd); check("mrst_edge", rd, 32'h0);
    bus_read(2'd3, rd); check("mrst_thr", rd, 32'd1000);
    bus_read(2'd1, rd); check("mrst_mask", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
